e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit with HI/LO registers for the five-stage pipeline. It accepts mult/multu/div/divu operands from the E stage, runs a fixed-latency multi-cycle operation, and holds a `busy` flag that the hazard unit uses to stall MDU instructions. It also serves mfhi/mflo/mthi/mtlo; its `MDU_out` result is carried to the M stage by the E/M pipeline register.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (`reset`=0 resets).
- `MDU_op`  in  4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- `start`  in  1: launch the multi-cycle op in `MDU_op` (1–4); one-cycle pulse.
- `V1`  in  32: rs operand (dividend, multiplicand, mthi/mtlo source).
- `V2`  in  32: rt operand (divisor, multiplier).
- `busy`  out  1: a multi-cycle op is in flight.
- `MDU_out`  out  32: HI for op 5, LO for op 6, else 0; combinational.
- `HI`  out  32: current HI register.
- `LO`  out  32: current LO register.

## Operation
- State: `HI`, `LO`, a 4-bit down-counter `cnt`, and pending result registers `hi_tmp` and `lo_tmp`. `busy` = (`cnt` != 0). States are IDLE (`cnt`=0) and RUN (`cnt`>0).
- Reset (`reset`=0, at any time including mid-operation): `HI`=0, `LO`=0, `cnt`=0, `hi_tmp`=0, `lo_tmp`=0. Outputs become `busy`=0, `MDU_out`=0. A pending result is discarded.
- IDLE, `start`=1 with op 1–4: compute the result from `V1`/`V2` as sampled at this edge, store it in `hi_tmp`/`lo_tmp`, and load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - mult: signed 64-bit product of `V1`×`V2`; HI = bits 63:32, LO = bits 31:0.
  - multu: unsigned 64-bit product, same split.
  - div: LO = signed quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div/divu): the op runs its full `DIV_CYCLES`, but `HI`/`LO` are left unchanged at completion.
- RUN: `cnt` decrements each edge. At the edge where `cnt`=1, `HI`<=`hi_tmp`, `LO`<=`lo_tmp`, and `cnt`<=0.
- `start` while `busy`=1, or `start` with an op outside 1–4: ignored.
- mthi (7) / mtlo (8) with `busy`=0: `HI`/`LO`<=`V1` at the edge. While `busy`=1 they are ignored; the hazard unit guarantees they never reach the unit while busy.
- mfhi/mflo read the register value current in that cycle; there is no forwarding from `hi_tmp`/`lo_tmp`.
- `start` and mthi/mtlo cannot coincide, because `MDU_op` is a single field.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from just after edge k through edge k+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - `HI`/`LO` hold their new values and `busy`=0 just after edge k+N.
- The hazard unit stalls any MDU instruction (`MDU_op` 1–8) in D while (`start` | `busy`). The unit does not stall itself.
- mfhi issued in the cycle right after `busy` falls returns the new HI.
- mthi at edge k: `HI` takes the new value just after edge k. An mfhi one cycle later reads it.
- `MDU_out` has no register stage; the downstream E/M pipeline register captures it.

## Test plan
- Reset mid-op: mult start, then `reset`=0 two cycles later → `busy`=0 immediately (asynchronous); `HI`=`LO`=0; no update after `reset` returns to 1.
- mult with `V1`=0xFFFFFFFF, `V2`=2 → `busy` high exactly 5 cycles; then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFE. Same operands with multu → `HI`=0x00000001, `LO`=0xFFFFFFFE.
- div with `V1`=0xFFFFFFF9 (−7), `V2`=2 → `busy` high exactly 10 cycles; `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. divu with `V1`=7, `V2`=2 → `LO`=3, `HI`=1.
- div by zero with `HI`=0x11, `LO`=0x22 preloaded → `busy` high 10 cycles; `HI`=0x11 and `LO`=0x22 unchanged afterwards.
- Second `start` (divu 100/3) during a running mult → ignored; `HI`/`LO` equal the mult result, and `busy` falls 5 cycles after the first `start`.
- mtlo `V1`=0xDEADBEEF, then mflo the next cycle → `MDU_out`=0xDEADBEEF. mfhi in the cycle after `busy` falls → returns the new HI.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Latency: mult/multu take MULT_CYCLES and div/divu take DIV_CYCLES edges; mthi/mtlo take one edge; MDU_out is combinational.
// Backpressure: busy is held while an op is in flight; the hazard unit stalls on it and the unit ignores start while busy.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  input  logic [31:0] V1,
  input  logic [31:0] V2,
  output logic        busy,
  output logic [31:0] MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [3:0]  cnt;
  logic [31:0] hi_tmp;
  logic [31:0] lo_tmp;

  logic        is_mul;
  logic        is_div;
  logic        launch;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy   = (cnt != 4'd0);
  assign is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
  assign is_div = (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
  assign launch = start && !busy && (is_mul || is_div);

  // Multipliers: low 64 bits of the sign-extended product give the signed result.
  assign prod_s = {{32{V1[31]}}, V1} * {{32{V2[31]}}, V2};
  assign prod_u = {32'd0, V1} * {32'd0, V2};

  // One unsigned divider on magnitudes; signs are restored afterwards so the
  // most-negative / -1 case wraps cleanly instead of relying on signed '/'.
  assign div_signed = (MDU_op == OP_DIV);
  assign a_neg      = div_signed && V1[31];
  assign b_neg      = div_signed && V2[31];
  assign a_mag      = a_neg ? (32'd0 - V1) : V1;
  assign b_mag      = b_neg ? (32'd0 - V2) : V2;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;

  // Select the pending result; divide-by-zero re-commits the current HI/LO.
  always_comb begin
    res_hi = HI;
    res_lo = LO;
    if (MDU_op == OP_MULT) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (MDU_op == OP_MULTU) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (is_div && (V2 != 32'd0)) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
    end
  end

  // Read port for mfhi/mflo; no forwarding from the pending result.
  always_comb begin
    MDU_out = 32'd0;
    if (MDU_op == OP_MFHI)      MDU_out = HI;
    else if (MDU_op == OP_MFLO) MDU_out = LO;
  end

  // Sequencer: countdown while running, commit on the last count, else launch or move-to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI     <= 32'd0;
      LO     <= 32'd0;
      cnt    <= 4'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end
    end else if (launch) begin
      hi_tmp <= res_hi;
      lo_tmp <= res_lo;
      cnt    <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    end else if (MDU_op == OP_MTHI) begin
      HI <= V1;
    end else if (MDU_op == OP_MTLO) begin
      LO <= V1;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus a randomized run against a plain-arithmetic model.
// Latency of each op is measured by counting cycles with busy high.
// Inputs change 1ns after the rising edge; outputs are sampled away from the edge.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  MDU_op;
  logic        start;
  logic [31:0] V1;
  logic [31:0] V2;
  logic        busy;
  logic [31:0] MDU_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDU_op(MDU_op), .start(start),
    .V1(V1), .V2(V2), .busy(busy), .MDU_out(MDU_out), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {HI, LO} after op completes, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = {hi, lo};
    case (op)
      4'd1: p = sa * sb;
      4'd2: p = ua * ub;
      4'd3: if (b != 32'd0) begin
              q = sa / sb;
              r = sa % sb;
              p = {r[31:0], q[31:0]};
            end
      4'd4: if (b != 32'd0) p = {a % b, a / b};
      default: ;
    endcase
    return p;
  endfunction

  // One cycle of stimulus: inputs held across the next rising edge, then cleared.
  task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    MDU_op = op; start = st; V1 = a; V2 = b;
    @(posedge clk); #1;
    MDU_op = 4'd0; start = 1'b0;
  endtask

  // Count cycles busy stays high from now on, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; MDU_op = 4'd0; start = 1'b0; V1 = 32'd0; V2 = 32'd0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", HI, LO); end
    MDU_op = 4'd5; #1;
    checks++; if (MDU_out !== 32'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", MDU_out); end
    MDU_op = 4'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    // Mid-operation reset discards the pending result.
    drive(4'd7, 1'b0, 32'hAA, 32'd0);
    drive(4'd8, 1'b0, 32'hBB, 32'd0);
    drive(4'd1, 1'b1, 32'hFFFFFFFF, 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL reset_mid_hilo got=%h/%h exp=0/0", HI, LO); end
    #2 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL reset_after busy=%b hi=%h lo=%h exp=0/0/0", busy, HI, LO);
    end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_mult;
    int n;
    drive(4'd1, 1'b1, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_cycles got=%0d exp=5", n); end
    checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL mult_result got=%h/%h exp=ffffffff/fffffffe", HI, LO);
    end
    drive(4'd2, 1'b1, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    // mfhi in the first cycle after busy falls sees the new HI.
    MDU_op = 4'd5; #1;
    checks++; if (MDU_out !== 32'h00000001) begin failures++; $display("FAIL multu_mfhi got=%h exp=00000001", MDU_out); end
    MDU_op = 4'd0;
    checks++; if (n != 5 || LO !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL multu_result cycles=%0d lo=%h exp=5/fffffffe", n, LO);
    end
    hi_m = 32'h1; lo_m = 32'hFFFFFFFE;
  endtask

  task automatic test_div;
    int n;
    drive(4'd3, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_cycles got=%0d exp=10", n); end
    checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      failures++; $display("FAIL div_result got=%h/%h exp=ffffffff/fffffffd", HI, LO);
    end
    drive(4'd4, 1'b1, 32'd7, 32'd2);
    wait_idle(n);
    checks++; if (n != 10 || HI !== 32'd1 || LO !== 32'd3) begin
      failures++; $display("FAIL divu_result cycles=%0d got=%h/%h exp=10/1/3", n, HI, LO);
    end
    hi_m = 32'd1; lo_m = 32'd3;
  endtask

  task automatic test_div_zero;
    int n;
    drive(4'd7, 1'b0, 32'h11, 32'd0);
    drive(4'd8, 1'b0, 32'h22, 32'd0);
    drive(4'd3, 1'b1, 32'h1234, 32'd0);
    wait_idle(n);
    checks++; if (n != 10) begin failures++; $display("FAIL divzero_cycles got=%0d exp=10", n); end
    checks++; if (HI !== 32'h11 || LO !== 32'h22) begin
      failures++; $display("FAIL divzero_hilo got=%h/%h exp=11/22", HI, LO);
    end
    hi_m = 32'h11; lo_m = 32'h22;
  endtask

  task automatic test_back_to_back;
    int n;
    drive(4'd1, 1'b1, 32'd3, 32'hFFFFFFFB);
    drive(4'd4, 1'b1, 32'd100, 32'd3);
    drive(4'd7, 1'b0, 32'h55, 32'd0);
    wait_idle(n);
    checks++; if (n + 2 != 5) begin failures++; $display("FAIL ignore_start_cycles got=%0d exp=5", n + 2); end
    checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1) begin
      failures++; $display("FAIL ignore_start_hilo got=%h/%h exp=ffffffff/fffffff1", HI, LO);
    end
    hi_m = 32'hFFFFFFFF; lo_m = 32'hFFFFFFF1;
  endtask

  task automatic test_move;
    drive(4'd8, 1'b0, 32'hDEADBEEF, 32'd0);
    MDU_op = 4'd6; #1;
    checks++; if (MDU_out !== 32'hDEADBEEF) begin failures++; $display("FAIL mtlo_mflo got=%h exp=deadbeef", MDU_out); end
    MDU_op = 4'd9; #1;
    checks++; if (MDU_out !== 32'd0) begin failures++; $display("FAIL out_other_op got=%h exp=0", MDU_out); end
    MDU_op = 4'd0;
    lo_m = 32'hDEADBEEF;
  endtask

  task automatic test_random;
    int n, r, exp_n;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      if (r < 2) begin
        op = (r == 0) ? 4'd7 : 4'd8;
        drive(op, 1'b0, a, 32'd0);
        if (op == 4'd7) hi_m = a; else lo_m = a;
        checks++; if (HI !== hi_m || LO !== lo_m) begin
          failures++; $display("FAIL rand_move op=%0d got=%h/%h exp=%h/%h", op, HI, LO, hi_m, lo_m);
        end
      end else begin
        op = 4'($urandom_range(1, 4));
        r = $urandom_range(0, 7);
        if (r == 0)      b = 32'd0;
        else if (r < 3)  b = $urandom_range(1, 9);
        else if (r == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        else             b = $urandom;
        e = model(op, a, b, hi_m, lo_m);
        exp_n = (op <= 4'd2) ? 5 : 10;
        drive(op, 1'b1, a, b);
        wait_idle(n);
        hi_m = e[63:32]; lo_m = e[31:0];
        checks++; if (n != exp_n) begin failures++; $display("FAIL rand_cycles op=%0d got=%0d exp=%0d", op, n, exp_n); end
        MDU_op = 4'd5; #1;
        checks++; if (MDU_out !== hi_m) begin
          failures++; $display("FAIL rand_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, MDU_out, hi_m);
        end
        MDU_op = 4'd6; #1;
        checks++; if (MDU_out !== lo_m) begin
          failures++; $display("FAIL rand_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, MDU_out, lo_m);
        end
        MDU_op = 4'd0;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    hi_m = 32'd0; lo_m = 32'd0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_back_to_back;
    test_move;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
